// File: rtl/coo_pkg.sv
// Shared types for the streaming COO sparse multiplier: entry record, FSM states
// and the accumulator width rule.
package coo_pkg;
  localparam int COO_DATA_W = 16;
  localparam int COO_IDX_W  = 4;

  typedef struct packed {
    logic [COO_IDX_W-1:0]         row;
    logic [COO_IDX_W-1:0]         col;
    logic signed [COO_DATA_W-1:0] val;
  } coo_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    EMIT
  } coo_state_t;

  // Full product plus enough headroom to sum INNER products, plus sign.
  function automatic int acc_width(input int data_w, input int inner);
    return 2 * data_w + $clog2(inner) + 1;
  endfunction
endpackage

// File: rtl/coo_entry_buf.sv
// Operand entry store: append-only register file whose write pointer is the
// entry count, with a sticky overflow flag and combinational indexed read.
module coo_entry_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 24,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          overflow
);
  logic [W-1:0] mem [DEPTH];

  // Writes past capacity are discarded but remembered in the overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (count < CW'(DEPTH)) begin
        mem[count[IW-1:0]] <= wr_data;
        count              <= count + CW'(1);
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/coo_spmm_stream.sv
// Streaming COO sparse matrix multiplier: loads A then B, sweeps every (A,B)
// entry pair once into a dense accumulator grid, then emits C row-major.
module coo_spmm_stream
  import coo_pkg::*;
#(
  parameter int DATA_W  = COO_DATA_W,
  parameter int IDX_W   = COO_IDX_W,
  parameter int ROWS    = 4,
  parameter int INNER   = 4,
  parameter int COLS    = 4,
  parameter int NNZ_MAX = 16,
  parameter int ACC_W   = acc_width(DATA_W, INNER)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sparse_out,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_row,
  input  logic [IDX_W-1:0]        in_col,
  input  logic signed [DATA_W-1:0] in_val,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_row,
  output logic [IDX_W-1:0]        out_col,
  output logic signed [ACC_W-1:0] out_val,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int CW    = $clog2(NNZ_MAX + 1);
  localparam int PW    = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;
  localparam int CELLS = ROWS * COLS;
  localparam int CPW   = $clog2(CELLS + 1);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;

  coo_state_t state, next_state;
  coo_entry_t in_ent, a_ent, b_ent;
  logic [CW-1:0] n_a, n_b;
  logic [PW-1:0] i_ptr, j_ptr;
  logic [CPW-1:0] pos, nxt_pos;
  logic [IDX_W-1:0] nxt_row, nxt_col;
  logic signed [ACC_W-1:0] nxt_val;
  logic signed [ACC_W-1:0] acc [ROWS][COLS];
  logic signed [2*DATA_W-1:0] prod;
  logic sparse_q, err_q, ovf_a, ovf_b;
  logic take, a_ok, b_ok, clear_bufs, empty, last_pair, hit;
  logic nxt_found, after_found, emit_done;

  assign in_ready   = (state == LOAD_A) || (state == LOAD_B);
  assign busy       = (state != IDLE);
  assign err        = err_q | ovf_a | ovf_b;
  assign take       = in_valid && in_ready;
  assign in_ent     = '{row: in_row, col: in_col, val: in_val};
  assign a_ok       = ({1'b0, in_row} < (IDX_W+1)'(ROWS))  && ({1'b0, in_col} < (IDX_W+1)'(INNER));
  assign b_ok       = ({1'b0, in_row} < (IDX_W+1)'(INNER)) && ({1'b0, in_col} < (IDX_W+1)'(COLS));
  assign clear_bufs = (state == IDLE) && start;

  coo_entry_buf #(.DEPTH(NNZ_MAX), .W($bits(coo_entry_t))) u_buf_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_bufs),
    .wr_en(take && (state == LOAD_A) && a_ok), .wr_data(in_ent),
    .rd_idx(i_ptr), .rd_data(a_ent), .count(n_a), .overflow(ovf_a)
  );

  coo_entry_buf #(.DEPTH(NNZ_MAX), .W($bits(coo_entry_t))) u_buf_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_bufs),
    .wr_en(take && (state == LOAD_B) && b_ok), .wr_data(in_ent),
    .rd_idx(j_ptr), .rd_data(b_ent), .count(n_b), .overflow(ovf_b)
  );

  // An empty operand still costs one COMPUTE cycle so the sweep timing is uniform.
  assign empty     = (n_a == '0) || (n_b == '0);
  assign last_pair = empty || ((CW'(i_ptr) == n_a - CW'(1)) && (CW'(j_ptr) == n_b - CW'(1)));
  assign hit       = !empty && (a_ent.col == b_ent.row);
  assign prod      = a_ent.val * b_ent.val;

  // Next emitted cell at or after pos, and whether another one follows it.
  always_comb begin
    nxt_found   = 1'b0;
    after_found = 1'b0;
    nxt_pos     = '0;
    nxt_row     = '0;
    nxt_col     = '0;
    nxt_val     = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((CPW'(r * COLS + c) >= pos) && (!sparse_q || (acc[r][c] != '0))) begin
          if (!nxt_found) begin
            nxt_found = 1'b1;
            nxt_pos   = CPW'(r * COLS + c);
            nxt_row   = IDX_W'(r);
            nxt_col   = IDX_W'(c);
            nxt_val   = acc[r][c];
          end else begin
            after_found = 1'b1;
          end
        end
      end
    end
  end

  assign emit_done = (out_valid && out_ready && out_last) || (!out_valid && !nxt_found);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD_A;
      LOAD_A:  if (take && in_last) next_state = LOAD_B;
      LOAD_B:  if (take && in_last) next_state = COMPUTE;
      COMPUTE: if (last_pair) next_state = EMIT;
      EMIT:    if (emit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sparse_q  <= 1'b0;
      err_q     <= 1'b0;
      i_ptr     <= '0;
      j_ptr     <= '0;
      pos       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_val   <= '0;
      done      <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          acc[r][c] <= '0;
    end else begin
      done <= (state != IDLE) && (next_state == IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            sparse_q <= sparse_out;
            err_q    <= 1'b0;
            i_ptr    <= '0;
            j_ptr    <= '0;
            pos      <= '0;
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                acc[r][c] <= '0;
          end
        end
        LOAD_A: if (take && !a_ok) err_q <= 1'b1;
        LOAD_B: if (take && !b_ok) err_q <= 1'b1;
        COMPUTE: begin
          if (hit)
            acc[a_ent.row[RW-1:0]][b_ent.col[CLW-1:0]] <=
              acc[a_ent.row[RW-1:0]][b_ent.col[CLW-1:0]] + ACC_W'(prod);
          if (empty || (CW'(j_ptr) == n_b - CW'(1))) begin
            j_ptr <= '0;
            i_ptr <= i_ptr + PW'(1);
          end else begin
            j_ptr <= j_ptr + PW'(1);
          end
        end
        EMIT: begin
          // Payload only reloads when the current beat is absent or accepted.
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (!out_valid || out_ready) begin
            out_valid <= nxt_found;
            if (nxt_found) begin
              out_row  <= nxt_row;
              out_col  <= nxt_col;
              out_val  <= nxt_val;
              out_last <= !after_found;
              pos      <= nxt_pos + CPW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/coo_spmm_stream.md
# coo_spmm_stream

Sequential, parametrised sparse-matrix multiplier for coordinate-format (COO) operands. It accepts matrix A and then matrix B as streams of (row, col, value) entries over one valid/ready channel. It computes C = A×B with a one-pair-per-cycle matching engine and streams C out in row-major order, either densely or as nonzero-only COO. It is the clocked, back-pressured generation of the team's combinational COO multiplier and sits between the COO loader and downstream result consumers.

## Interface
- DATA_W, 16: signed element width of A/B values
- IDX_W, 4: row/col index width
- ROWS, 4: rows of A and C
- INNER, 4: cols of A = rows of B
- COLS, 4: cols of B and C
- NNZ_MAX, 16: entry capacity per operand buffer
- ACC_W, 2*DATA_W+$clog2(INNER)+1: signed accumulator/output width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin job; honoured only in IDLE
- sparse_out  in  1  sampled at start: 1 = emit nonzeros only, 0 = emit all ROWS*COLS
- in_valid / in_ready  in/out  1  entry handshake
- in_row, in_col  in  IDX_W  entry coordinates
- in_val  in  DATA_W  entry value, signed
- in_last  in  1  marks final entry of current operand
- out_valid / out_ready  out/in  1  result handshake
- out_row, out_col  out  IDX_W  result coordinates
- out_val  out  ACC_W  result value, signed
- out_last  out  1  final result beat of job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky error; cleared by start or reset

## Operation
- FSM: IDLE → LOAD_A → LOAD_B → COMPUTE → EMIT → IDLE.
- IDLE: start → LOAD_A; counts nA=nB=0, err=0, all accumulators cleared in the same edge.
- LOAD_A/LOAD_B: in_ready=1. Each handshake stores the entry at the operand count, then increments the count. A handshake with in_last advances the state (A→B, B→COMPUTE).
- Entries beyond NNZ_MAX are dropped and set err. A handshake is still taken.
- Out-of-range coordinates (row/col ≥ the matrix dimension) are dropped and set err.
- Duplicate coordinates are legal; their contributions add.
- COMPUTE: nested pointers i over A[0..nA-1] (outer) and j over B[0..nB-1] (inner), one pair per cycle. If A[i].col == B[j].row, then acc[A[i].row][B[j].col] += A[i].val*B[j].val.
- Arithmetic is signed and full-precision into ACC_W, with wrap on overflow (no saturation).
- EMIT: scan (r,c) row-major. Dense mode presents every cell. Sparse mode skips cells with acc==0 and needs no bubble per skipped cell (next-nonzero search is combinational or prefetched). out_last accompanies the final emitted beat.
- Sparse mode with zero nonzeros emits no beats: EMIT → IDLE directly, with a done pulse.
- done pulses the cycle the FSM re-enters IDLE.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_row=out_col=out_val=0, busy=0, done=0, err=0, state=IDLE.
- Reset mid-job aborts at the next edge: all outputs take their reset values, counts are cleared, and any partial output is lost.
- start while busy is ignored.
- COMPUTE lasts exactly max(nA*nB,1) cycles, then EMIT begins on the next edge.
- Output outputs are registered. out_valid holds and the payload is stable until out_ready.
- Beat throughput is 1/cycle when out_ready=1.
- Dense EMIT lasts ROWS*COLS cycles with no backpressure.
- Input latency: the entry is visible to compute the cycle after its handshake.

## Structure
- Shared package coo_pkg:
  - coo_entry_t struct {row, col, val}
  - state enum
  - ACC_W helper function
- Sub-module coo_entry_buf (instantiated twice, for A and B): NNZ_MAX-deep register file with write pointer, count, overflow flag and asynchronous indexed read.

## Test plan
- Reference job, dense:
  - A = {(0,0,4),(0,3,2),(1,2,1),(2,1,2),(3,0,9),(3,2,2)}
  - B = {(0,0,2),(0,2,8),(0,3,2),(1,2,1),(2,0,3),(2,2,4),(3,1,1),(3,2,2)}
  - Required: COMPUTE = 48 cycles; 16 beats, rows {8,2,36,8}, {3,0,4,0}, {0,0,2,0}, {24,0,80,18}; out_last on (3,3).
- Same job, sparse_out=1 → exactly 10 beats, in row-major order, e.g. (0,0,8)…(3,3,18); out_last on (3,3,18).
- Random out_ready (50%) on the reference job → same sequence, no drops or duplicates, payload stable while stalled.
- Negative values: A=(0,0,-32768), B=(0,0,-32768) → (0,0)=1073741824, no wrap.
- Error cases:
  - NNZ_MAX+1 A entries → err=1 and the last entry ignored.
  - Entry (4,0,1) → err=1 and result unaffected.
- Empty B (single in_last beat flagged out-of-range) with sparse_out=1 → no output beats, done pulses.
- Reset asserted mid-EMIT → next cycle out_valid=0, busy=0; a fresh start computes correctly.
